instr_ram_debug_loader: RTL and testbench
=========================================

INSTR_RAM_DEBUG_LOADER -- requirements
Module: instr_ram_debug_loader

Interface
REQ-001 Parameter: RX_TIMEOUT, default 1023; maximum idle cycles allowed between bytes inside one command.
REQ-002 Parameter: ERR_W, default 8; width of the error counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock, shared with the instruction RAM.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 rx_data  in  8  command byte from the host link.
REQ-007 rx_valid  in  1  rx_data is valid.
REQ-008 rx_ready  out  1  loader accepts a byte this cycle.
REQ-009 tx_data  out  8  response byte to the host link.
REQ-010 tx_valid  out  1  tx_data is valid.
REQ-011 tx_ready  in  1  host link accepts a byte this cycle.
REQ-012 ram_web  out  1  RAM port-b write enable.
REQ-013 ram_addrb  out  30  RAM port-b word address, byte address bits [31:2].
REQ-014 ram_dinb  out  32  RAM port-b write data.
REQ-015 ram_doutb  in  32  RAM port-b read data; synchronous, 1-cycle latency.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err_cnt  out  ERR_W  saturating count of bad opcodes and timeouts.

Function
REQ-018 A byte SHALL transfer only when valid and ready are both high on a rising edge.
REQ-019 Multi-byte fields SHALL be little-endian (LSB first).
REQ-020 FSM states SHALL be IDLE, ADDR, DATA, WRITE, RD_REQ, RD_WAIT, SEND.
REQ-021 rx_ready SHALL be high only in IDLE, ADDR and DATA; tx_valid SHALL be high only in SEND.
REQ-022 IDLE: opcode 0x57 ('W') or 0x52 ('R') -> ADDR.
REQ-023 IDLE: any other opcode SHALL be dropped, increment err_cnt, and remain in IDLE.
REQ-024 ADDR: accept 4 bytes; ram_addrb SHALL take byte-address bits [31:2]; bits [1:0] are ignored. Then 'W' -> DATA, 'R' -> RD_REQ.
REQ-025 DATA: accept 4 bytes into ram_dinb, then -> WRITE.
REQ-026 WRITE: ram_web SHALL be high for exactly this one cycle, with ram_addrb and ram_dinb stable; then -> IDLE.
REQ-027 RD_REQ: hold ram_addrb for one cycle; -> RD_WAIT.
REQ-028 RD_WAIT: capture ram_doutb at the end of the cycle; -> SEND.
REQ-029 SEND: emit the 4 captured bytes LSB first, each held until tx_ready; after the 4th transfer -> IDLE.
REQ-030 Timeout: in ADDR or DATA, RX_TIMEOUT consecutive cycles without a transfer SHALL abort to IDLE, increment err_cnt, and issue no write.
REQ-031 The timeout counter SHALL clear on every accepted byte.
REQ-032 SEND SHALL have no timeout; back-pressure is unbounded.
REQ-033 err_cnt SHALL saturate at all-ones; a bad opcode and a timeout cannot occur in the same cycle.
REQ-034 ram_web SHALL never be high outside WRITE.

Reset
REQ-035 When rst_n is low at a rising edge: state=IDLE, ram_web=0, ram_addrb=0, ram_dinb=0, tx_data=0, tx_valid=0, err_cnt=0, counters=0.
REQ-036 Reset mid-command SHALL discard the partial command; no write is issued in the reset cycle.

Configuration
REQ-037 Macro DBG_LOADER_AUTOINC_EN.
REQ-038 When defined: opcode 0x4E ('N') -> DATA, with ram_addrb = last write address + 1 word (wraps at 2^30), then a normal WRITE; the last-write address resets to 0.
REQ-039 When not defined: 0x4E is a bad opcode (REQ-023).

Structure
REQ-040 Package dbg_loader_pkg SHALL hold the opcode constants (0x57, 0x52, 0x4E) and the FSM state enum.
REQ-041 One sub-module, dbg_word_shifter, SHALL handle the 4-byte assemble/serialize register and the byte index counter.

Verification
REQ-042 Bytes 57 00 01 00 00 EF BE AD DE -> one ram_web pulse, ram_addrb=0x40, ram_dinb=0xDEADBEEF.
REQ-043 RAM preloaded word 0x40 = 0x12345678; bytes 52 00 01 00 00 -> tx bytes 78 56 34 12; tx_ready held low for 5 cycles mid-stream stalls the output without loss.
REQ-044 Byte 0x41 -> err_cnt=1, no write, no tx; a following valid 'W' command completes normally.
REQ-045 Bytes 57 10 00 then RX_TIMEOUT idle cycles -> IDLE, err_cnt increments, ram_web never asserted.
REQ-046 With DBG_LOADER_AUTOINC_EN: write to 0x100, then 4E + 4 data bytes -> write at word address 0x41; without the macro -> err_cnt increments.
REQ-047 rst_n low for one cycle after the 6th byte of a 'W' command -> no write, all outputs at their reset values.

Source files
------------

// File: rtl/dbg_loader_pkg.sv
// dbg_loader_pkg: opcodes and FSM states shared by the debug loader files.
package dbg_loader_pkg;
  localparam logic [7:0] OP_WR  = 8'h57;
  localparam logic [7:0] OP_RD  = 8'h52;
  localparam logic [7:0] OP_INC = 8'h4E;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RD_REQ, RD_WAIT, SEND} state_t;
endpackage

// File: rtl/dbg_word_shifter.sv
// dbg_word_shifter: 4-byte little-endian assemble/serialize register with byte index.
module dbg_word_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic        shift_in,
  input  logic        shift_out,
  input  logic [7:0]  din_byte,
  input  logic [31:0] load_word,
  output logic [31:0] nxt_word,
  output logic [7:0]  out_byte,
  output logic        last
);
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  always_comb begin
    nxt_word = {din_byte, word_q[31:8]};
    word_d = load ? load_word : shift_in ? nxt_word : shift_out ? {8'h00, word_q[31:8]} : word_q;
    idx_d = (clr || load) ? 2'd0 : (shift_in || shift_out) ? idx_q + 2'd1 : idx_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end
  assign out_byte = word_q[7:0];
  assign last = idx_q == 2'd3;
endmodule

// File: rtl/instr_ram_debug_loader.sv
// instr_ram_debug_loader: byte-stream host loader for instruction RAM port b.
// DBG_LOADER_AUTOINC_EN enables the 'N' write-next-word opcode.
module instr_ram_debug_loader
  import dbg_loader_pkg::*;
#(
  parameter int RX_TIMEOUT = 1023,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             ram_web,
  output logic [29:0]      ram_addrb,
  output logic [31:0]      ram_dinb,
  input  logic [31:0]      ram_doutb,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  state_t           state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      din_q, din_d, nxt_word;
  logic             rd_q, rd_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             err_inc, sh_in, sh_load, sh_out, last, rx_fire, tx_fire;
`ifdef DBG_LOADER_AUTOINC_EN
  logic [29:0]      lastw_q, lastw_d;
`endif
  assign rx_ready  = state_q inside {IDLE, ADDR, DATA};
  assign tx_valid  = state_q == SEND;
  assign busy      = state_q != IDLE;
  assign ram_web   = state_q == WRITE;
  assign ram_addrb = addr_q;
  assign ram_dinb  = din_q;
  assign err_cnt   = err_q;
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  dbg_word_shifter u_shift (
    .clk(clk), .rst_n(rst_n), .clr(state_q == IDLE), .load(sh_load),
    .shift_in(sh_in), .shift_out(sh_out), .din_byte(rx_data), .load_word(ram_doutb),
    .nxt_word(nxt_word), .out_byte(tx_data), .last(last)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_d    = rd_q;
    tmo_d   = tmo_q;
    err_inc = 1'b0;
    sh_in   = 1'b0;
    sh_load = 1'b0;
    sh_out  = 1'b0;
`ifdef DBG_LOADER_AUTOINC_EN
    lastw_d = lastw_q;
`endif
    case (state_q)
      IDLE: if (rx_fire) begin
        if (rx_data == OP_WR || rx_data == OP_RD) begin
          rd_d    = rx_data == OP_RD;
          state_d = ADDR;
        end
`ifdef DBG_LOADER_AUTOINC_EN
        else if (rx_data == OP_INC) begin
          addr_d  = lastw_q + 30'd1;
          state_d = DATA;
        end
`endif
        else err_inc = 1'b1;
      end
      ADDR, DATA: if (rx_fire) begin
        sh_in = 1'b1;
        tmo_d = '0;
        if (last && state_q == ADDR) begin
          addr_d  = nxt_word[31:2];
          state_d = rd_q ? RD_REQ : DATA;
        end else if (last) begin
          din_d   = nxt_word;
          state_d = WRITE;
        end
      end else if (tmo_q == TW'(RX_TIMEOUT - 1)) begin
        tmo_d   = '0;
        err_inc = 1'b1;
        state_d = IDLE;
      end else tmo_d = tmo_q + 1'b1;
      WRITE: begin
`ifdef DBG_LOADER_AUTOINC_EN
        lastw_d = addr_q;
`endif
        state_d = IDLE;
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        sh_load = 1'b1;
        state_d = SEND;
      end
      SEND: if (tx_fire) begin
        sh_out  = 1'b1;
        state_d = last ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q + ERR_W'(err_inc && !(&err_q));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      tmo_q   <= '0;
      err_q   <= '0;
`ifdef DBG_LOADER_AUTOINC_EN
      lastw_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`ifdef DBG_LOADER_AUTOINC_EN
      lastw_q <= lastw_d;
`endif
    end
  end
endmodule

// File: tb/tb_instr_ram_debug_loader.sv
// tb_instr_ram_debug_loader: table-driven commands with write/tx scoreboards.
module tb_instr_ram_debug_loader;
  localparam int RX_TIMEOUT = 1023;
  localparam int ERR_W = 8;
  logic clk = 1'b0;
  logic rst_n, rx_valid, rx_ready, tx_valid, tx_ready, ram_web, busy;
  logic [7:0] rx_data, tx_data;
  logic [29:0] ram_addrb;
  logic [31:0] ram_dinb, ram_doutb;
  logic [ERR_W-1:0] err_cnt;
  always #5 clk = ~clk;
  instr_ram_debug_loader #(.RX_TIMEOUT(RX_TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .ram_web(ram_web),
    .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb), .busy(busy),
    .err_cnt(err_cnt)
  );
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_web) mem[ram_addrb[7:0]] <= ram_dinb;
    ram_doutb <= mem[ram_addrb[7:0]];
  end
  typedef struct packed { logic [29:0] a; logic [31:0] d; } wr_t;
  typedef struct {
    int n; logic [71:0] b; logic w; logic [29:0] wa; logic [31:0] wd; logic r; logic [31:0] rw; int err;
  } vec_t;
  wr_t wq [$];
  logic [7:0] tq [$];
  wr_t wexp;
  vec_t tv [9];
  int n_cmp = 0, n_err = 0, exp_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (ram_web) begin
    if (wq.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addrb, ram_dinb);
    end else begin
      wexp = wq.pop_front();
      chk("wr_addr", 32'(ram_addrb), 32'(wexp.a));
      chk("wr_data", ram_dinb, wexp.d);
    end
  end
  always @(negedge clk) if (tx_valid && tx_ready) begin
    if (tq.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_tx: got %h expected no byte", tx_data);
    end else chk("tx_byte", 32'(tx_data), 32'(tq.pop_front()));
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask
  task automatic send_bytes(input int n, input logic [71:0] b);
    for (int k = 0; k < n; k++) send_byte(b[71-8*k -: 8]);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) chk("idle_wait", 32'(busy), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[8'h40] <= 32'h12345678;
    tv[0] = '{5, 72'h52_00_01_00_00_00_00_00_00, 1'b0, 30'h0,  32'h0,        1'b1, 32'h12345678, 0};
    tv[1] = '{9, 72'h57_00_01_00_00_EF_BE_AD_DE, 1'b1, 30'h40, 32'hDEADBEEF, 1'b0, 32'h0,        0};
    tv[2] = '{5, 72'h52_00_01_00_00_00_00_00_00, 1'b0, 30'h0,  32'h0,        1'b1, 32'hDEADBEEF, 0};
    tv[3] = '{1, 72'h41_00_00_00_00_00_00_00_00, 1'b0, 30'h0,  32'h0,        1'b0, 32'h0,        1};
    tv[4] = '{9, 72'h57_07_02_00_00_11_22_33_44, 1'b1, 30'h81, 32'h44332211, 1'b0, 32'h0,        1};
    tv[5] = '{5, 72'h52_04_02_00_00_00_00_00_00, 1'b0, 30'h0,  32'h0,        1'b1, 32'h44332211, 1};
    tv[6] = '{9, 72'h57_00_01_00_00_0D_F0_FE_CA, 1'b1, 30'h40, 32'hCAFEF00D, 1'b0, 32'h0,        1};
`ifdef DBG_LOADER_AUTOINC_EN
    tv[7] = '{5, 72'h4E_01_02_03_04_00_00_00_00, 1'b1, 30'h41, 32'h04030201, 1'b0, 32'h0,        1};
    tv[8] = '{1, 72'h00_00_00_00_00_00_00_00_00, 1'b0, 30'h0,  32'h0,        1'b0, 32'h0,        2};
`else
    tv[7] = '{1, 72'h4E_00_00_00_00_00_00_00_00, 1'b0, 30'h0,  32'h0,        1'b0, 32'h0,        2};
    tv[8] = '{1, 72'h00_00_00_00_00_00_00_00_00, 1'b0, 30'h0,  32'h0,        1'b0, 32'h0,        3};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_web", 32'(ram_web), 32'd0);
    chk("rst_addrb", 32'(ram_addrb), 32'd0);
    chk("rst_dinb", ram_dinb, 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (tv[i].w) wq.push_back({tv[i].wa, tv[i].wd});
      if (tv[i].r) for (int k = 0; k < 4; k++) tq.push_back(tv[i].rw[8*k +: 8]);
      send_bytes(tv[i].n, tv[i].b);
      wait_idle();
      chk($sformatf("vec%0d_err", i), 32'(err_cnt), 32'(tv[i].err));
      chk($sformatf("vec%0d_wq", i), 32'(wq.size()), 32'd0);
      chk($sformatf("vec%0d_tq", i), 32'(tq.size()), 32'd0);
    end
    exp_err = tv[8].err;
    // read with a five-cycle tx stall after the first byte
    for (int k = 0; k < 4; k++) tq.push_back(8'(32'hCAFEF00D >> (8*k)));
    send_bytes(5, 72'h52_00_01_00_00_00_00_00_00);
    begin
      int n = 0;
      while (!tx_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
    end
    chk("stall_tx_start", 32'(tx_valid), 32'd1);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("stall_tx_valid", 32'(tx_valid), 32'd1);
    chk("stall_tx_data", 32'(tx_data), 32'hF0);
    chk("stall_busy", 32'(busy), 32'd1);
    tx_ready = 1'b1;
    wait_idle();
    chk("stall_tq", 32'(tq.size()), 32'd0);
    send_bytes(3, 72'h57_10_00_00_00_00_00_00_00);
    repeat (RX_TIMEOUT - 1) begin
      @(posedge clk); #1;
    end
    chk("tmo_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("tmo_after", 32'(busy), 32'd0);
    exp_err++;
    chk("tmo_err", 32'(err_cnt), 32'(exp_err));
    send_bytes(6, 72'h57_00_02_00_00_11_00_00_00);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_addrb", 32'(ram_addrb), 32'd0);
    chk("mid_rst_dinb", ram_dinb, 32'd0);
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_web", 32'(ram_web), 32'd0);
    wq.push_back({30'hC0, 32'h55AA55AA});
    send_bytes(9, 72'h57_00_03_00_00_AA_55_AA_55);
    wait_idle();
    for (int k = 0; k < 4; k++) tq.push_back(8'(32'h55AA55AA >> (8*k)));
    send_bytes(5, 72'h52_00_03_00_00_00_00_00_00);
    wait_idle();
    chk("post_rst_err", 32'(err_cnt), 32'd0);
    repeat (260) send_byte(8'hFF);
    wait_idle();
    chk("err_saturate", 32'(err_cnt), 32'hFF);
    chk("final_wq", 32'(wq.size()), 32'd0);
    chk("final_tq", 32'(tq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
